// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial packed-BCD adder/subtractor.
// Operands are latched on start, then one BCD digit is processed per clock
// through a single one-digit decimal add stage, with the decimal carry
// passed from each digit to the next. Subtraction adds the nines' complement
// of y with an initial carry of one, giving the ten's complement difference.

module bcd_serial_addsub_ctrl #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 4*DIGITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             carry,
   output logic             err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] x_q, y_q;
   logic             sub_q;
   logic [IDX_W-1:0] idx;
   logic             c;

   logic [3:0]       xd, yd, yd_eff, dig;
   logic [4:0]       sum;
   logic             c_nxt;
   logic             bad_in;

   // Flag any non-decimal digit (>9) in either incoming operand
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((x[4*i +: 4] > 4'd9) || (y[4*i +: 4] > 4'd9))
            bad_in = 1'b1;
      end
   end

   // One-digit decimal add stage on the digit selected by idx
   always_comb begin
      xd     = x_q[4*idx +: 4];
      yd     = y_q[4*idx +: 4];
      yd_eff = sub_q ? (4'd9 - yd) : yd;
      sum    = {1'b0, xd} + {1'b0, yd_eff} + {4'b0000, c};
      dig    = sum[3:0];
      c_nxt  = 1'b0;
      if (sum > 5'd9) begin
         dig   = 4'(sum - 5'd10);
         c_nxt = 1'b1;
      end
   end

   // State register; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: bad operands skip RUN, DONE always returns to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start)
               state_nxt = bad_in ? DONE : RUN;
         end
         RUN: begin
            if (idx == LAST_IDX)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture and digit-by-digit result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         sub_q <= 1'b0;
         idx   <= '0;
         c     <= 1'b0;
         z     <= '0;
         carry <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x_q   <= x;
                  y_q   <= y;
                  sub_q <= op_sub;
                  z     <= '0;
                  err   <= bad_in;
                  idx   <= '0;
                  c     <= op_sub;
                  if (bad_in)
                     carry <= 1'b0;
               end
            end
            RUN: begin
               z[4*idx +: 4] <= dig;
               c             <= c_nxt;
               idx           <= idx + IDX_W'(1);
               if (idx == LAST_IDX)
                  carry <= c_nxt;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Bench for the digit-serial BCD add/subtract sequencer.
// Each issued operation queues its expected result; a negedge monitor pops
// the queue whenever done is seen and compares z, carry, err and the number
// of busy cycles that preceded it.

module tb_bcd_serial_addsub_ctrl;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 4*DIGITS;

   typedef struct {
      logic [WIDTH-1:0] z;
      logic             carry;
      logic             err;
      int               busy_cycles;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] z;
   logic             carry;
   logic             err;

   exp_t exp_q[$];
   exp_t cur;
   int   checks   = 0;
   int   errors   = 0;
   int   busy_cnt = 0;

   bcd_serial_addsub_ctrl #(.DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_sub (op_sub),
      .x      (x),
      .y      (y),
      .busy   (busy),
      .done   (done),
      .z      (z),
      .carry  (carry),
      .err    (err)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and log a failure line on mismatch
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Issue one start pulse and queue the result it should produce
   task automatic apply_stimulus(input logic sub, input logic [WIDTH-1:0] xv,
                                 input logic [WIDTH-1:0] yv, input logic [WIDTH-1:0] ez,
                                 input logic ec, input logic ee, input int eb);
      exp_t e;
      e.z = ez;
      e.carry = ec;
      e.err = ee;
      e.busy_cycles = eb;
      @(posedge clk);
      #1;
      start  = 1'b1;
      op_sub = sub;
      x      = xv;
      y      = yv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start  = 1'b0;
      x      = $urandom;
      y      = $urandom;
      op_sub = $urandom_range(0, 1);
   endtask

   // Wait for done with a bounded cycle budget
   task automatic wait_done(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 50);
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no done expected done within 50 cycles", name);
      end
   endtask

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy)
            busy_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
               cur = exp_q.pop_front();
               check_output("z", 32'(z), 32'(cur.z));
               check_output("carry", 32'(carry), 32'(cur.carry));
               check_output("err", 32'(err), 32'(cur.err));
               check_output("busy_cycles", 32'(busy_cnt), 32'(cur.busy_cycles));
            end
            busy_cnt = 0;
         end
      end
   end

   // Directed stimulus sequence
   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      op_sub = 1'b0;
      x      = '0;
      y      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_z", 32'(z), 32'd0);
      check_output("reset_carry", 32'(carry), 32'd0);
      check_output("reset_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      apply_stimulus(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, DIGITS);
      wait_done("add_basic");

      apply_stimulus(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, DIGITS);
      wait_done("add_ripple");

      apply_stimulus(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, DIGITS);
      wait_done("sub_pos");
      apply_stimulus(1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0, DIGITS);
      wait_done("sub_neg");

      apply_stimulus(1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0);
      wait_done("bad_digit");
      apply_stimulus(1'b0, 16'h0042, 16'h0058, 16'h0100, 1'b0, 1'b0, DIGITS);
      wait_done("err_clear");

      apply_stimulus(1'b0, 16'h2500, 16'h2500, 16'h5000, 1'b0, 1'b0, DIGITS);
      @(posedge clk);
      #1;
      start  = 1'b1;
      op_sub = 1'b1;
      x      = 16'h9999;
      y      = 16'h1111;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wait_done("start_ignored");

      apply_stimulus(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, DIGITS);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      check_output("abort_z", 32'(z), 32'd0);
      check_output("abort_carry", 32'(carry), 32'd0);
      check_output("abort_err", 32'(err), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      apply_stimulus(1'b0, 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0, DIGITS);
      wait_done("after_reset");

      repeat (3) @(negedge clk);
      check_output("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
